weight_pingpong_ram: RTL
========================

// Module: weight_pingpong_ram
// PURPOSE
// - Double-buffered (ping-pong) banked weight store between the AXI-lite/DMA weight loader and the conv PE array.
// - Loader fills the write page one beat per bank in round-robin order.
// - PE array reads all banks of the read page in parallel via kernel_addr.
// - A swap exchanges the two pages, so loading layer N+1 overlaps computing layer N. Reads are never blocked by writes.
// PARAMETERS
// - pWEIGHT_DATA_WIDTH  64            bits per bank word
// - pWEIGHT_BASE_ADDR   32'h4000_0000 byte-agnostic word base of the weight window
// - pKERNEL_NUM         1024          words per bank per page
// - pBLOCK_RAM_NUM      8             banks; any value >=1, need not be a power of 2
// - pREAD_LATENCY       2             rd_req -> rd_valid cycles; legal range 1..4
// PORTS
// - clk          in   1     single clock
// - rst          in   1     asynchronous, active-high reset
// - wr_valid     in   1     write beat valid
// - wr_ready     out  1     write page can accept a beat (= !page_full)
// - wr_addr      in   32    word address; kernel index = wr_addr - pWEIGHT_BASE_ADDR
// - wr_data      in   DW    beat data
// - wr_last      in   1     final beat of a page load
// - wr_err       out  1     1-cycle pulse: accepted beat was out of window
// - swap         in   1     request page exchange
// - page_full    out  1     write page loaded, awaiting swap
// - rd_page      out  1     index of the current read page
// - rd_req       in   1     read request
// - kernel_addr  in   clog2(KN)              read kernel index
// - rd_valid     out  1                      kernel_data valid
// - kernel_data  out  DW*pBLOCK_RAM_NUM      bank b in slice [b*DW +: DW]
// BEHAVIOUR
// - Reset: wr_ready=1, wr_err=0, page_full=0, rd_page=1 (write page 0), bank_idx=0, rd_valid pipe=0, kernel_data=0. Memory contents are not cleared.
// - Write accept: wr_valid && wr_ready.
//   - In window (BASE <= wr_addr < BASE+KN; upper bound exclusive): write bank[bank_idx][~rd_page][wr_addr-BASE].
//   - bank_idx advances: wraps N-1 -> 0, non-power-of-two safe.
// - Out-of-window accepted beat:
//   - Dropped; wr_err=1 next cycle for one cycle.
//   - bank_idx unchanged.
//   - If it carries wr_last, the page still completes.
// - Accepted wr_last: page_full<=1 and bank_idx<=0 next cycle. The page is full regardless of how many beats were written.
// - Swap: honoured only if registered page_full==1.
//   - Effect: rd_page toggles and page_full<=0.
//   - Swap in the same cycle as wr_last is ignored; a swap one cycle later is honoured.
//   - A swap while not full is ignored silently.
// - Read: rd_req samples kernel_addr and rd_page together.
//   - kernel_data and rd_valid appear exactly pREAD_LATENCY cycles later.
//   - Fully pipelined: one request per cycle.
//   - In-flight reads issued before a swap return old-page data.
//   - kernel_data holds its value when rd_valid=0.
// - No read/write collision: writes target only ~rd_page. Each bank is simple dual-port (1W + 1R per cycle).
// - Async reset mid-load or mid-read: outputs take reset values immediately, in-flight reads are discarded, and the next load starts at bank 0.
// STRUCTURE
// - Package weight_buf_pkg:
//   - BANK_IDX_W = max(1, clog2(pBLOCK_RAM_NUM)).
//   - KADDR_W = clog2(pKERNEL_NUM).
//   - typedef logic page_t.
//   - Function in_window(addr, base, kn).
// - Sub-module weight_bank_sdp: one simple dual-port bank, ram_style "ultra".
//   - Depth 2*pKERNEL_NUM; address = {page, kaddr}.
//   - Output registered; extra latency stages added in the top level.
//   - Instantiated pBLOCK_RAM_NUM times via generate.
// - Top level: bank_idx counter, page/full control, wr_err, and the rd_valid/rd_page shift pipeline.
// TESTING (bench params: KN=16, N=3, DW=16, LAT=2)
// - Fill: 48 in-window beats with data={bank,kidx}, wr_last on beat 48.
//   - Expect page_full=1 and wr_ready=0 next cycle.
//   - Swap -> rd_page=0 and page_full=0.
// - Read: rd_req with kernel_addr=5, two cycles after the swap.
//   - Expect rd_valid after exactly 2 cycles, kernel_data={16'h0205,16'h0105,16'h0005}.
//   - Back-to-back rd_req 0..15 gives 16 consecutive rd_valid cycles.
// - Overlap: stream reads of page 0 while loading page 1 with new data.
//   - Page 0 read data unchanged throughout.
//   - After the next swap, reads return page-1 data; in-flight reads issued before the swap return page-0 data.
// - Window: wr_addr=BASE+16 then BASE-1.
//   - wr_err pulses once for each; no memory change.
//   - The following in-window beat lands in the same bank as before.
// - Swap rules:
//   - Swap with page_full=0 -> no change.
//   - Swap in the same cycle as wr_last -> ignored; swap on the next cycle -> rd_page toggles.
// - Async reset: assert rst between clock edges mid-load with reads in flight.
//   - Outputs reach reset values before the next edge and rd_valid never fires.
//   - After release, the first beat writes bank 0.

Source files
------------

// File: rtl/weight_buf_pkg.sv
// Purpose : Shared types and helpers for the ping-pong weight buffer.
// Contents: page_t, address width constant, width helpers for the bank
//           index and kernel address, and the write-window check.
package weight_buf_pkg;

    typedef logic page_t;

    localparam int unsigned ADDR_W = 32;

    // Bank index width; a single bank still gets a 1-bit index.
    function automatic int unsigned bank_idx_w(input int unsigned n_banks);
        return (n_banks <= 2) ? 1 : $clog2(n_banks);
    endfunction

    function automatic int unsigned kaddr_w(input int unsigned kn);
        return $clog2(kn);
    endfunction

    // True when base <= addr < base + kn. Done in 33 bits so a window that
    // touches the top of the address space does not wrap.
    function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] base,
                                       input int unsigned       kn);
        logic [ADDR_W:0] a;
        logic [ADDR_W:0] lo;
        logic [ADDR_W:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + (ADDR_W+1)'(kn);
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/weight_bank_sdp.sv
// Purpose : One simple dual-port weight bank holding both pages.
//           Address is {page, kernel index}; read data is registered and
//           only updates on a read enable, so it holds between reads.
// Ports   : i_clk, i_rst (async, active-high, clears read register only)
//           i_we / i_waddr / i_wdata   write port
//           i_re / i_raddr / o_rdata   read port, 1-cycle registered
module weight_bank_sdp
    import weight_buf_pkg::*;
#(
    parameter int unsigned pDW     = 64,
    parameter int unsigned pADDR_W = 11
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_we,
    input  logic [pADDR_W-1:0] i_waddr,
    input  logic [pDW-1:0]     i_wdata,
    input  logic               i_re,
    input  logic [pADDR_W-1:0] i_raddr,
    output logic [pDW-1:0]     o_rdata
);

    // Two pages of kernel words; equals 2*pKERNEL_NUM for power-of-two KN.
    localparam int unsigned DEPTH = 2 ** pADDR_W;

    (* ram_style = "ultra" *) logic [pDW-1:0] r_mem [DEPTH];
    logic [pDW-1:0] r_rdata;

    // Memory array itself has no reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/weight_pingpong_ram.sv
// Purpose : Double-buffered banked weight store. The loader fills the write
//           page one beat per bank in round-robin order; the PE array reads
//           every bank of the read page in parallel. A swap exchanges pages.
// Ports   : i_clk, i_rst (async, active-high)
//           write: i_wr_valid, o_wr_ready, i_wr_addr, i_wr_data, i_wr_last,
//                  o_wr_err (1-cycle pulse for a dropped out-of-window beat)
//           page : i_swap, o_page_full, o_rd_page
//           read : i_rd_req, i_kernel_addr, o_rd_valid, o_kernel_data
//                  (bank b in o_kernel_data[b*DW +: DW])
module weight_pingpong_ram
    import weight_buf_pkg::*;
#(
    parameter int unsigned pWEIGHT_DATA_WIDTH = 64,
    parameter logic [31:0] pWEIGHT_BASE_ADDR  = 32'h4000_0000,
    parameter int unsigned pKERNEL_NUM        = 1024,
    parameter int unsigned pBLOCK_RAM_NUM     = 8,
    parameter int unsigned pREAD_LATENCY      = 2
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst,
    input  logic                                         i_wr_valid,
    output logic                                         o_wr_ready,
    input  logic [31:0]                                  i_wr_addr,
    input  logic [pWEIGHT_DATA_WIDTH-1:0]                i_wr_data,
    input  logic                                         i_wr_last,
    output logic                                         o_wr_err,
    input  logic                                         i_swap,
    output logic                                         o_page_full,
    output logic                                         o_rd_page,
    input  logic                                         i_rd_req,
    input  logic [kaddr_w(pKERNEL_NUM)-1:0]              i_kernel_addr,
    output logic                                         o_rd_valid,
    output logic [pWEIGHT_DATA_WIDTH*pBLOCK_RAM_NUM-1:0] o_kernel_data
);

    localparam int unsigned DW         = pWEIGHT_DATA_WIDTH;
    localparam int unsigned NB         = pBLOCK_RAM_NUM;
    localparam int unsigned LAT        = pREAD_LATENCY;
    localparam int unsigned KADDR_W    = kaddr_w(pKERNEL_NUM);
    localparam int unsigned BANK_IDX_W = bank_idx_w(pBLOCK_RAM_NUM);
    localparam int unsigned KD_W       = DW * NB;

    logic [BANK_IDX_W-1:0] r_bank_idx;
    logic                  r_page_full;
    page_t                 r_rd_page;
    logic                  r_wr_err;
    logic [LAT-1:0]        r_rd_vld;

    logic                  w_accept;
    logic                  w_in_win;
    logic                  w_bank_wr;
    logic [KADDR_W-1:0]    w_kidx;
    page_t                 w_wr_page;
    logic [KD_W-1:0]       w_bank_dout;

    assign w_accept  = i_wr_valid & ~r_page_full;
    assign w_in_win  = in_window(i_wr_addr, pWEIGHT_BASE_ADDR, pKERNEL_NUM);
    assign w_bank_wr = w_accept & w_in_win;
    assign w_kidx    = KADDR_W'(i_wr_addr - pWEIGHT_BASE_ADDR);
    assign w_wr_page = ~r_rd_page;

    // Write/page control. A beat is only accepted while the page is not
    // full, so a wr_last and an honoured swap can never coincide: a swap in
    // the wr_last cycle sees page_full=0 and is dropped.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bank_idx  <= '0;
            r_page_full <= 1'b0;
            r_rd_page   <= 1'b1;
            r_wr_err    <= 1'b0;
        end else begin
            r_wr_err <= w_accept & ~w_in_win;
            if (w_accept && i_wr_last) begin
                r_page_full <= 1'b1;
                r_bank_idx  <= '0;
            end else if (w_bank_wr) begin
                r_bank_idx <= (r_bank_idx == BANK_IDX_W'(NB - 1))
                              ? '0 : r_bank_idx + 1'b1;
            end
            if (i_swap && r_page_full) begin
                r_rd_page   <= ~r_rd_page;
                r_page_full <= 1'b0;
            end
        end
    end

    // Valid shift register; bit 0 marks bank output data valid.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_vld <= '0;
        end else begin
            r_rd_vld <= LAT'({r_rd_vld, i_rd_req});
        end
    end

    // The read page is captured into the bank address in the request
    // cycle, so reads in flight across a swap still return old-page data.
    for (genvar b = 0; b < NB; b++) begin : g_bank
        weight_bank_sdp #(
            .pDW     (DW),
            .pADDR_W (KADDR_W + 1)
        ) u_bank (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_we    (w_bank_wr && (r_bank_idx == BANK_IDX_W'(b))),
            .i_waddr ({w_wr_page, w_kidx}),
            .i_wdata (i_wr_data),
            .i_re    (i_rd_req),
            .i_raddr ({r_rd_page, i_kernel_addr}),
            .o_rdata (w_bank_dout[b*DW +: DW])
        );
    end

    // Extra latency stages. Each stage loads only when the data entering
    // it is valid, so the final stage holds its value between reads.
    wire [KD_W-1:0] w_stage [LAT];
    assign w_stage[0] = w_bank_dout;

    for (genvar s = 1; s < LAT; s++) begin : g_lat
        logic [KD_W-1:0] r_q;
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_q <= '0;
            end else if (r_rd_vld[s-1]) begin
                r_q <= w_stage[s-1];
            end
        end
        assign w_stage[s] = r_q;
    end

    assign o_kernel_data = w_stage[LAT-1];
    assign o_rd_valid    = r_rd_vld[LAT-1];
    assign o_wr_ready    = ~r_page_full;
    assign o_wr_err      = r_wr_err;
    assign o_page_full   = r_page_full;
    assign o_rd_page     = r_rd_page;

endmodule
